// File: rtl/mod7_counter.sv
// Free-running modulo-MODULUS counter with terminal-count flag, a one-cycle
// wrap pulse and a running count of wraps since reset.
module mod7_counter #(
  parameter int MODULUS = 7,
  parameter int WIDTH   = 3,
  parameter int WRAPW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic [WRAPW-1:0] wrap_count
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
      $error("mod7_counter: MODULUS must lie in 2..2**WIDTH");
    end
  endgenerate

  assign tc = (count == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      wrap       <= 1'b0;
      wrap_count <= '0;
    end else begin
      wrap <= (count == LAST);
      if (count == LAST)
        wrap_count <= wrap_count + 1'b1;
      // >= also pulls an out-of-range value back to 0
      count <= (count >= LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mod7_counter.sv
// Scoreboard bench: three counter variants (default, WRAPW=2, MODULUS=5)
// share clock and reset; a reference model predicts every edge.
module tb_mod7_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic [2:0] c0, c1, c2;
  logic       tc0, tc1, tc2;
  logic       w0, w1, w2;
  logic [7:0] wc0;
  logic [1:0] wc1;
  logic [7:0] wc2;

  mod7_counter u_def (.clk(clk), .rst(rst), .count(c0), .tc(tc0), .wrap(w0), .wrap_count(wc0));
  mod7_counter #(.MODULUS(7), .WIDTH(3), .WRAPW(2)) u_w2
    (.clk(clk), .rst(rst), .count(c1), .tc(tc1), .wrap(w1), .wrap_count(wc1));
  mod7_counter #(.MODULUS(5), .WIDTH(3), .WRAPW(8)) u_m5
    (.clk(clk), .rst(rst), .count(c2), .tc(tc2), .wrap(w2), .wrap_count(wc2));

  always #10 clk = ~clk;

  typedef struct {
    int cnt  [3];
    int tc   [3];
    int wrap [3];
    int wc   [3];
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int mod_v  [3] = '{7, 7, 5};
  int wmask  [3] = '{255, 3, 255};
  int m_cnt  [3];
  int m_wrap [3];
  int m_wc   [3];

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      e.cnt[i]  = m_cnt[i];
      e.tc[i]   = (m_cnt[i] == mod_v[i] - 1) ? 1 : 0;
      e.wrap[i] = m_wrap[i];
      e.wc[i]   = m_wc[i];
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_wrap[i] = 0; m_wc[i] = 0;
    end
  endtask

  task automatic compare_all(input string ph);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s: scoreboard empty", ph);
      return;
    end
    e = exp_q.pop_front();
    chk({ph, " def.count"}, 32'(c0),  e.cnt[0]);
    chk({ph, " def.tc"},    32'(tc0), e.tc[0]);
    chk({ph, " def.wrap"},  32'(w0),  e.wrap[0]);
    chk({ph, " def.wc"},    32'(wc0), e.wc[0]);
    chk({ph, " w2.count"},  32'(c1),  e.cnt[1]);
    chk({ph, " w2.wc"},     32'(wc1), e.wc[1]);
    chk({ph, " w2.wrap"},   32'(w1),  e.wrap[1]);
    chk({ph, " m5.count"},  32'(c2),  e.cnt[2]);
    chk({ph, " m5.tc"},     32'(tc2), e.tc[2]);
    chk({ph, " m5.wrap"},   32'(w2),  e.wrap[2]);
    chk({ph, " m5.wc"},     32'(wc2), e.wc[2]);
  endtask

  // one clock edge: predict, push, wait, pop and compare
  task automatic step(input string ph);
    for (int i = 0; i < 3; i++) begin
      m_wrap[i] = (m_cnt[i] == mod_v[i] - 1) ? 1 : 0;
      if (m_wrap[i] != 0) m_wc[i] = (m_wc[i] + 1) & wmask[i];
      m_cnt[i] = (m_cnt[i] >= mod_v[i] - 1) ? 0 : m_cnt[i] + 1;
    end
    exp_q.push_back(snap());
    @(posedge clk);
    #1;
    compare_all(ph);
  endtask

  task automatic check_now(input string ph);
    exp_q.push_back(snap());
    compare_all(ph);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // reset from time zero, checked immediately and after two periods
    rst = 1'b0;
    model_reset();
    #1;
    check_now("rst_early");
    repeat (2) @(posedge clk);
    #1;
    check_now("rst_hold");

    rst = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      step("run");
      if (k == 20) begin
        chk("long.count", 32'(c0),  6);
        chk("long.wc",    32'(wc0), 2);
        chk("long.tc",    32'(tc0), 1);
      end
      if (k == 21) chk("roll.wc3", 32'(wc1), 3);
      if (k == 28) begin
        chk("roll.wc0",   32'(wc1), 0);
        chk("roll.count", 32'(c1),  0);
      end
    end

    // advance default counter to 4, then reset between edges
    repeat (4) step("pre_abort");
    chk("abort.pre", 32'(c0), 4);
    #4;
    rst = 1'b0;
    model_reset();
    #1;
    check_now("async_rst");
    chk("abort.wc", 32'(wc0), 0);
    @(posedge clk);
    #3;
    check_now("rst_hold2");
    rst = 1'b1;

    for (int k = 1; k <= 16; k++) begin
      step("resume");
      if (k == 1) chk("resume.first", 32'(c0), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mod7_counter.md
MOD7_COUNTER -- requirements
Module: mod7_counter

Interface
REQ-001 Parameter MODULUS, default 7, number of distinct count states (legal range 2..2**WIDTH).
REQ-002 Parameter WIDTH, default 3, bit width of count.
REQ-003 Parameter WRAPW, default 8, bit width of the wrap counter.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-low reset.
REQ-006 Port count  output  WIDTH  current counter value, registered.
REQ-007 Port tc  output  1  terminal-count flag, high while count == MODULUS-1.
REQ-008 Port wrap  output  1  registered one-cycle pulse, high for the cycle after count wraps MODULUS-1 -> 0.
REQ-009 Port wrap_count  output  WRAPW  number of wraps since reset, modulo 2**WRAPW.
REQ-010 There SHALL be one clock, and reset SHALL be asynchronous and active-low.
REQ-011 There SHALL be no enable, load or direction input; the counter runs freely whenever out of reset.

Function
REQ-012 On each rising clk edge with rst high, count SHALL increment by 1 when count < MODULUS-1.
REQ-013 On the rising edge where count == MODULUS-1, count SHALL become 0 on that edge.
- Default sequence: 0,1,2,3,4,5,6,0,...
REQ-014 count SHALL never hold a value >= MODULUS.
- Corruption recovery: if count somehow holds a value >= MODULUS, the next edge SHALL load 0.
REQ-015 tc SHALL be combinational from count (count == MODULUS-1), with no extra latency.
REQ-016 wrap SHALL be set to 1 on the edge where count goes MODULUS-1 -> 0, and cleared to 0 on every other edge.
REQ-017 wrap_count SHALL increment by 1 on the same edge that sets wrap.
- wrap_count SHALL roll over from 2**WRAPW-1 to 0 silently.
REQ-018 Latency: count, wrap and wrap_count SHALL update on the same edge; no pipeline stages.
REQ-019 The design SHALL flag an illegal parameter set at elaboration time.
- Illegal: MODULUS < 2, or MODULUS > 2**WIDTH.

Reset
REQ-020 While rst is low, count SHALL be 0, wrap SHALL be 0 and wrap_count SHALL be 0.
- These values SHALL apply immediately, independent of clk.
REQ-021 tc SHALL be 0 during reset (because count == 0 and MODULUS >= 2).
REQ-022 Asserting rst mid-count SHALL clear all state asynchronously, with no completion of the current cycle.
REQ-023 After rst deasserts, the first rising edge SHALL move count from 0 to 1.

Verification
REQ-024 Reset check: hold rst low for 2 clock periods (20 ns period) -> count=0, tc=0, wrap=0, wrap_count=0 throughout.
REQ-025 Sequence check: release rst, apply 7 edges -> count reads 1,2,3,4,5,6,0.
- tc=1 only while count=6.
- wrap=1 only in the cycle after count returns to 0.
REQ-026 Long run: apply 20 edges after reset release -> count=6, wrap_count=2, tc=1.
REQ-027 Asynchronous reset mid-count: drive rst low between edges while count=4 -> count=0 and wrap_count=0 before the next edge.
- Counting SHALL resume 1,2,... after release.
REQ-028 Wrap-counter rollover: with WRAPW=2, run 28 edges -> wrap_count sequence 1,2,3,0, with count=0 at the 28th edge.
REQ-029 Parameter variant: MODULUS=5, WIDTH=3 -> count sequence 0,1,2,3,4,0, with tc=1 at count=4.
